// File: rtl/pcnt_arb_pkg.sv
// Shared types and helpers for the round-robin popcount arbiter.
package pcnt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int STATS_CNT_W = 16;

  // Modulo increment; the wrap is explicit so n need not be a power of 2.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pcnt_engine.sv
// Registered popcount engine: one-cycle latency, valid travels with the data.
module pcnt_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic [CNT_W-1:0] data_o,
  output logic             data_val_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             val_q;

  // Sum of set bits in the incoming word.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CNT_W'(data_i[i]);
    end
  end

  // Register count and valid together so they stay aligned.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
      val_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= data_val_i;
    end
  end

  assign data_o     = cnt_q;
  assign data_val_o = val_q;

endmodule

// File: rtl/pcnt_rr_arbiter.sv
// Round-robin arbiter sharing one popcount engine among NUM_REQ requesters.
// Optional per-requester grant counters: define PCNT_RR_ARBITER_STATS_EN.
module pcnt_rr_arbiter
  import pcnt_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = $clog2(WIDTH) + 1,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_val_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [CNT_W-1:0]         res_data_o,
  output logic [ID_W-1:0]          res_id_o,
  output logic                     res_val_o,
  input  logic                     res_ready_i
`ifdef PCNT_RR_ARBITER_STATS_EN
  ,output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt_o
`endif
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic             res_val_q, res_val_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic             accept;
  logic             eng_val_in;
  logic [CNT_W-1:0] eng_data;
  logic             eng_val_out;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_val_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // A transfer only happens in IDLE and never while reset is asserted.
  assign accept = (state_q == IDLE) && grant_found && !srst_i;

  // Ready is one-hot on the winner during the accepting cycle, else zero.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_id] = 1'b1;
  end

  assign eng_val_in = (state_q == ISSUE);

  pcnt_engine #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_engine (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .data_i     (word_q),
    .data_val_i (eng_val_in),
    .data_o     (eng_data),
    .data_val_o (eng_val_out)
  );

  // Next-state and datapath updates for IDLE -> ISSUE -> WAIT -> OUT.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    word_d     = word_q;
    id_d       = id_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_val_d  = res_val_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = req_data_i[grant_id*WIDTH +: WIDTH];
          id_d    = grant_id;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (eng_val_out) begin
          res_data_d = eng_data;
          res_id_d   = id_q;
          res_val_d  = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (res_ready_i) begin
          res_val_d = 1'b0;
          rr_ptr_d  = ID_W'(rr_next(int'(id_q), NUM_REQ));
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight or held result.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      word_q     <= '0;
      id_q       <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_val_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      word_q     <= word_d;
      id_q       <= id_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_val_q  <= res_val_d;
    end
  end

  assign res_data_o = res_data_q;
  assign res_id_o   = res_id_q;
  assign res_val_o  = res_val_q;

`ifdef PCNT_RR_ARBITER_STATS_EN
  // One wrapping grant counter per requester, bumped on each accept.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [STATS_CNT_W-1:0] cnt_q, cnt_d;

    // Increment when this requester wins the transfer.
    always_comb begin
      cnt_d = cnt_q;
      if (accept && (grant_id == ID_W'(gi))) cnt_d = cnt_q + STATS_CNT_W'(1);
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i) begin
      if (srst_i) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign grant_cnt_o[gi*STATS_CNT_W +: STATS_CNT_W] = cnt_q;
  end
`endif

endmodule

// File: doc/pcnt_rr_arbiter.md
Name: pcnt_rr_arbiter

Overview:
- Shares one popcount engine between NUM_REQ requesters using a round-robin arbiter.
- Each requester offers a WIDTH-bit word with a valid/ready handshake.
- The block issues the winning word to the engine, captures the bit count, and returns it tagged with the requester ID.
- Output has its own valid/ready handshake so the consumer can stall the block.

Parameters:
- WIDTH, 8: data word width per requester.
- CNT_W, $clog2(WIDTH)+1: result width; must hold the value WIDTH.
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, $clog2(NUM_REQ): requester ID width.

Ports:
- clk_i  in  1  single clock, rising edge.
- srst_i  in  1  synchronous reset, active-high.
- req_data_i  in  NUM_REQ*WIDTH  packed request words; requester k occupies bits [k*WIDTH +: WIDTH].
- req_val_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester ready; one-hot or zero.
- res_data_o  out  CNT_W  number of set bits in the granted word.
- res_id_o  out  ID_W  index of the requester that owns the result.
- res_val_o  out  1  result valid.
- res_ready_i  in  1  consumer ready.

Behaviour:
- Reset: FSM=IDLE, rr_ptr=0, res_data_o=0, res_id_o=0, res_val_o=0, req_ready_o=0; the engine's valid is cleared.
- Reset mid-transaction: the in-flight request and any held result are dropped, with no output pulse.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - Pick the first k with req_val_i[k]=1, searching from rr_ptr upward with wrap.
  - req_ready_o[k]=1 combinationally for the winner only; the transfer occurs this cycle.
  - Latch the word and its ID, then go to ISSUE.
  - If no request is valid, stay in IDLE with req_ready_o=0.
- ISSUE: drive the engine with the latched word and engine valid=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - The engine has 1-cycle registered latency.
  - On the engine result valid, load res_data_o and res_id_o, set res_val_o=1, go to OUT.
- OUT:
  - Hold res_val_o, res_data_o and res_id_o stable until res_val_o && res_ready_i.
  - On that handshake: clear res_val_o, set rr_ptr=(granted ID+1) mod NUM_REQ, go to IDLE.
- Timing:
  - Latency from request accept to res_val_o is 3 cycles.
  - Maximum throughput is 1 result per 4 cycles with res_ready_i held at 1.
- Arithmetic:
  - The count is unsigned and ranges 0..WIDTH.
  - The rr_ptr wrap is explicit: NUM_REQ need not be a power of 2.
- Requests:
  - A requester must hold data and valid until it sees ready.
  - Deasserting req_val_i before the grant is legal, and that requester is skipped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 grants.
- Overlap rule: requests arriving during ISSUE, WAIT or OUT are not accepted until the next IDLE.

Optional Feature:
- Macro: PCNT_RR_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_cnt_o, NUM_REQ*16 bits.
  - One 16-bit counter per requester increments on each accepted request and wraps at 0xFFFF->0.
  - All counters clear on srst_i.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package pcnt_arb_pkg holds:
  - the state_t enum {IDLE, ISSUE, WAIT, OUT};
  - function rr_next(ptr, n), the modulo increment;
  - the STATS_CNT_W=16 constant.
- One sub-module, pcnt_engine:
  - parameters WIDTH and CNT_W;
  - ports clk_i, srst_i, data_i, data_val_i, data_o, data_val_o;
  - registered popcount with 1-cycle latency; data_val_o follows data_val_i by one cycle.

Test Plan:
- Reset then idle: all req_val_i=0 for 10 cycles -> req_ready_o=0, res_val_o=0, outputs 0.
- Single requester: req 2 sends 0xB5 once, res_ready_i=1 -> 3 cycles after accept: res_data_o=5, res_id_o=2, one-cycle res_val_o.
- Full contention: all 4 valid with words 0x00, 0xFF, 0x0F, 0x01, res_ready_i=1 -> results in ID order 0,1,2,3 with counts 0, 8, 4, 1, then grant returns to 0.
- Backpressure: res_ready_i=0 for 5 cycles after res_val_o rises -> outputs stable, no req_ready_o, result delivered when ready goes to 1.
- Wrap and skip: rr_ptr=3 and only req 1 valid -> req 1 granted; next pointer=2.
- Reset during WAIT: srst_i pulse -> res_val_o never asserts; next request starts from rr_ptr=0.
- With PCNT_RR_ARBITER_STATS_EN: 3 grants to req 0 and 1 grant to req 3 -> grant_cnt_o fields = 3,0,0,1.
